truth_table_sweeper: RTL

//   Self-contained exhaustive stimulus/capture engine for N-input, 1-output combinational blocks.
//   It is the parametrised successor to hand-written 4-input truth-table benches.
//   On start it drives all 2^N_IN input vectors in ascending order, holds each for HOLD_CYCLES clocks,

---
 rtl/truth_table_sweeper.sv | 122 ++++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus/capture engine: walks all 2^N_IN input vectors, captures a
// 1-bit DUT response per vector and scores it against an expected truth table.
module truth_table_sweeper #(
  parameter int unsigned N_IN        = 4,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   exp_table,
  input  logic                   z_in,
  output logic [N_IN-1:0]        vec_out,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_out,
  output logic [N_IN:0]          ones_count,
  output logic [N_IN:0]          fail_count,
  output logic [N_IN-1:0]        first_fail_idx
);

  localparam int unsigned N_VEC = 1 << N_IN;
  localparam int unsigned CW    = N_IN + 1;
  localparam int unsigned HW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [N_IN-1:0] VEC_LAST  = N_IN'(N_VEC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [HW-1:0]     hold_cnt, hold_nxt;
  logic [N_IN-1:0]   vec_nxt;
  logic              busy_nxt, done_nxt;
  logic [N_VEC-1:0]  table_nxt;
  logic [CW-1:0]     ones_nxt, fail_nxt;
  logic [N_IN-1:0]   first_nxt;
  logic              mismatch;

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      hold_cnt       <= '0;
      vec_out        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      table_out      <= '0;
      ones_count     <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
    end else begin
      state          <= state_nxt;
      hold_cnt       <= hold_nxt;
      vec_out        <= vec_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      table_out      <= table_nxt;
      ones_count     <= ones_nxt;
      fail_count     <= fail_nxt;
      first_fail_idx <= first_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    vec_nxt   = vec_out;
    busy_nxt  = busy;
    done_nxt  = done;
    table_nxt = table_out;
    ones_nxt  = ones_count;
    fail_nxt  = fail_count;
    first_nxt = first_fail_idx;
    mismatch  = (z_in != exp_table[vec_out]);

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_APPLY;
          hold_nxt  = '0;
          vec_nxt   = '0;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          table_nxt = '0;
          ones_nxt  = '0;
          fail_nxt  = '0;
          first_nxt = '0;
        end
      end

      S_APPLY: begin
        if (hold_cnt != HOLD_LAST) begin
          hold_nxt = hold_cnt + HW'(1);
        end else begin
          // Capture edge: DUT has had HOLD_CYCLES clocks to settle
          table_nxt[vec_out] = z_in;
          ones_nxt           = ones_count + CW'(z_in);
          if (mismatch) begin
            fail_nxt = fail_count + CW'(1);
            if (fail_count == '0) first_nxt = vec_out;
          end
          if (vec_out == VEC_LAST) begin
            state_nxt = S_DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            vec_nxt  = vec_out + N_IN'(1);
            hold_nxt = '0;
          end
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
